// File: rtl/uart_rx_pkg.sv
// Shared types and helpers for the UART receive path.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } rx_state_t;

    typedef enum logic [1:0] {
        PAR_NONE = 2'b00,
        PAR_EVEN = 2'b01,
        PAR_ODD  = 2'b10
    } parity_mode_t;

    function automatic int unsigned calc_div(input int unsigned clk, input int unsigned baud);
        return clk / baud;
    endfunction

endpackage

// File: rtl/uart_rx_fifo_ctl_if.sv
// Received-character stream: head-of-queue character with error flags, valid/ready drained.
interface uart_rx_fifo_ctl_if #(
    parameter int unsigned BITS = 8
);
    logic [BITS-1:0] out_data;
    logic            out_perr;
    logic            out_ferr;
    logic            out_valid;
    logic            out_ready;

    modport master (
        output out_data,
        output out_perr,
        output out_ferr,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_perr,
        input  out_ferr,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/uart_rx_sfifo.sv
// Generic synchronous FIFO; pointers carry one extra bit to tell full from empty.
module uart_rx_sfifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, rd_ptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + (AW + 1)'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + (AW + 1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
    end
endmodule

// File: rtl/uart_rx_fifo_ctl.sv
// UART receiver with mid-bit sampling, per-character error flags and a queued output.
// Define UART_RX_PARITY_EN to build the parity stage and the perr FIFO bit.
module uart_rx_fifo_ctl
    import uart_rx_pkg::*;
#(
    parameter int unsigned CLK        = 50000000,
    parameter int unsigned BAUD_RATE  = 115200,
    parameter int unsigned BITS       = 8,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               rx,
    input  logic [1:0]         parity_mode,
    uart_rx_fifo_ctl_if.master fifo_out,
    output logic               overrun,
    output logic               busy
);
    localparam int unsigned DIV = calc_div(CLK, BAUD_RATE);
    localparam int unsigned CW  = $clog2(DIV) + 1;
    localparam int unsigned IW  = $clog2(BITS) + 1;
`ifdef UART_RX_PARITY_EN
    localparam int unsigned EW  = BITS + 2;
`else
    localparam int unsigned EW  = BITS + 1;
`endif
    localparam logic [CW-1:0] HALF_CNT  = CW'((DIV - 1) / 2);
    localparam logic [CW-1:0] BIT_CNT   = CW'(DIV - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(BITS - 1);
    localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

    rx_state_t       state_q, state_d;
    logic            rx_meta_q, rx_s_q;
    logic [CW-1:0]   clkd_q;
    logic [IW-1:0]   index_q;
    logic [BITS-1:0] data_q;
    logic            ferr_q, stop_cnt_q, push_q;
    logic            mid_tick, bit_tick, last_stop, stop_done;
    logic [EW-1:0]   wdata, rdata;
    logic            fifo_full, fifo_empty, pop;
`ifdef UART_RX_PARITY_EN
    logic [1:0]      mode_q;
    logic            perr_q, par_en;

    assign par_en = (mode_q == PAR_EVEN) || (mode_q == PAR_ODD);
`else
    logic            unused_parity_mode;

    assign unused_parity_mode = ^parity_mode;
`endif

    assign mid_tick  = (clkd_q == HALF_CNT);
    assign bit_tick  = (clkd_q == BIT_CNT);
    assign last_stop = (stop_cnt_q == STOP_LAST);

    // Idle-high synchroniser so reset never looks like a start bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (!rx_s_q) state_d = START;
            START: if (mid_tick) state_d = rx_s_q ? IDLE : DATA;
            DATA: begin
                if (bit_tick && index_q == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
                    state_d = par_en ? PARITY : STOP;
`else
                    state_d = STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: if (bit_tick) state_d = STOP;
`endif
            STOP: begin
                if (bit_tick && last_stop) state_d = (ferr_q || !rx_s_q) ? BREAK : IDLE;
            end
            BREAK: if (rx_s_q) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state_q != IDLE);
        stop_done = (state_q == STOP) && bit_tick && last_stop;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clkd_q     <= '0;
            index_q    <= '0;
            data_q     <= '0;
            ferr_q     <= 1'b0;
            stop_cnt_q <= 1'b0;
            push_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
            mode_q     <= '0;
            perr_q     <= 1'b0;
`endif
        end else begin
            // The entry is captured one cycle after the last stop sample.
            push_q <= stop_done;
            case (state_q)
                IDLE: begin
                    clkd_q     <= '0;
                    index_q    <= '0;
                    ferr_q     <= 1'b0;
                    stop_cnt_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
                    mode_q     <= parity_mode;
                    perr_q     <= 1'b0;
`endif
                end
                START: clkd_q <= mid_tick ? '0 : clkd_q + CW'(1);
                DATA: begin
                    if (bit_tick) begin
                        clkd_q  <= '0;
                        data_q  <= {rx_s_q, data_q[BITS-1:1]};
                        index_q <= index_q + IW'(1);
                    end else begin
                        clkd_q  <= clkd_q + CW'(1);
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (bit_tick) begin
                        clkd_q <= '0;
                        perr_q <= ((^data_q) ^ rx_s_q) != (mode_q == PAR_ODD);
                    end else begin
                        clkd_q <= clkd_q + CW'(1);
                    end
                end
`endif
                STOP: begin
                    if (bit_tick) begin
                        clkd_q     <= '0;
                        stop_cnt_q <= stop_cnt_q + 1'b1;
                        if (!rx_s_q) ferr_q <= 1'b1;
                    end else begin
                        clkd_q     <= clkd_q + CW'(1);
                    end
                end
                default: clkd_q <= '0;
            endcase
        end
    end

`ifdef UART_RX_PARITY_EN
    assign wdata             = {data_q, perr_q, ferr_q};
    assign fifo_out.out_perr = !fifo_empty && rdata[1];
`else
    assign wdata             = {data_q, ferr_q};
    assign fifo_out.out_perr = 1'b0;
`endif

    uart_rx_sfifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_q),
        .wdata (wdata),
        .pop   (pop),
        .rdata (rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign pop                = !fifo_empty && fifo_out.out_ready;
    assign overrun            = push_q && fifo_full && !pop;
    assign fifo_out.out_valid = !fifo_empty;
    // Storage is not reset; mask the head so outputs read 0 while empty.
    assign fifo_out.out_data  = fifo_empty ? '0 : rdata[EW-1 -: BITS];
    assign fifo_out.out_ferr  = !fifo_empty && rdata[0];
endmodule

// File: doc/uart_rx_fifo_ctl.md
Name: uart_rx_fifo_ctl

Overview:
Parametrised successor of the single-byte UART receiver.
- Synchronises rx and checks the start bit at mid-bit, then samples data bits LSB first.
- Runtime-selectable parity, configurable stop bits, and framing/parity error flags per character.
- Received characters are queued in a small FIFO and drained through a valid/ready handshake. Feeds the UART-to-PS/2 bridge logic.

Parameters:
CLK, 50000000, system clock frequency in Hz
BAUD_RATE, 115200, line rate; DIV = CLK/BAUD_RATE, DIV >= 8
BITS, 8, data bits per character, legal 5..9
STOP_BITS, 1, stop bits checked, 1 or 2
FIFO_DEPTH, 4, queued characters, power of two, >= 2

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
rx  in  1  serial line, idle high, asynchronous to clk
parity_mode  in  2  00 none, 01 even, 10 odd, 11 none; sampled only in IDLE
out_data  out  BITS  head-of-FIFO character
out_perr  out  1  parity error for head character
out_ferr  out  1  framing error for head character
out_valid  out  1  FIFO not empty
out_ready  in  1  consumer accepts head when high with out_valid
overrun  out  1  one-cycle pulse: completed character dropped, FIFO full
busy  out  1  high in every state except IDLE

Behaviour:
- Reset: all outputs 0, FIFO empty, state IDLE, counters 0, rx synchroniser flops set to 1. Reset mid-frame abandons the frame with no push.
- Input: rx passes through a 2-flop synchroniser giving rx_s; all sampling uses rx_s (2-cycle input lag).
- State machine: IDLE, START, DATA, PARITY, STOP, BREAK.
- IDLE: clkd = 0, index = 0, latch parity_mode. On rx_s == 0 go to START.
- START: count clkd to (DIV-1)/2, then sample. rx_s == 0 goes to DATA with clkd = 0. rx_s == 1 is a glitch: return to IDLE, no push.
- DATA: sample every DIV clocks into data[index], LSB first. After BITS samples, go to PARITY if parity is enabled, else STOP.
- PARITY: sample after DIV clocks.
  - Even mode: perr = XOR(data, parity bit) != 0.
  - Odd mode: perr = XOR(data, parity bit) != 1.
- STOP: sample STOP_BITS times, DIV apart; ferr = 1 if any stop sample is 0.
  - After the last stop sample: push {data, perr, ferr}.
  - If ferr == 0, go to IDLE on the next cycle (mid-stop-bit re-arm).
  - If ferr == 1, go to BREAK.
- BREAK: wait until rx_s == 1, then go to IDLE. A held-low line yields exactly one ferr character.
- Latency: out_valid rises on the clock edge after the final stop sample edge when the FIFO was empty.
- FIFO: out_valid = !empty. Pop on out_valid && out_ready.
  - Push when full with no pop: character dropped, overrun pulses one cycle, FIFO contents unchanged.
  - Push and pop in the same cycle when full: both accepted, no overrun.
  - Push and pop in the same cycle otherwise: both accepted, occupancy unchanged.
  - Pointers wrap modulo FIFO_DEPTH; an extra pointer bit distinguishes full from empty.
- Arithmetic: clkd width is $clog2(DIV)+1. index width is $clog2(BITS)+1.

Optional Feature:
UART_RX_PARITY_EN
- Defined: PARITY state present; parity_mode honoured; out_perr driven from the FIFO entry.
- Undefined: PARITY state and perr FIFO bit removed. parity_mode is ignored (port kept), out_perr tied to 0, DATA goes directly to STOP.

Decomposition:
- Package uart_rx_pkg holds:
  - rx_state_t enum {IDLE, START, DATA, PARITY, STOP, BREAK}
  - parity_mode_t (PAR_NONE = 2'b00, PAR_EVEN = 2'b01, PAR_ODD = 2'b10)
  - function calc_div(clk, baud) returning CLK/BAUD_RATE
- Sub-module uart_rx_sfifo: generic synchronous FIFO (WIDTH, DEPTH) with push/pop/full/empty. Same clk/reset convention; storage not reset, pointers reset.

Test Plan:
1. CLK=50 MHz, BAUD=115200 (DIV=434), mode none; send 0x55 8N1 -> one entry out_data=0x55, perr=0, ferr=0; out_valid 1 cycle after the stop sample.
2. Even parity; send 0xA3 with parity bit 1 (wrong) -> out_data=0xA3, perr=1. Repeat with parity bit 0 -> perr=0. Without UART_RX_PARITY_EN -> perr=0 and the next frame is misframed as expected.
3. Send 0x3C with stop bit 0, then hold rx low 20 bit-times -> exactly one entry with ferr=1, busy stays high until rx returns high, then the next 0x12 frame is received cleanly.
4. Low pulse of DIV/4 clocks on idle line -> no entry, state back to IDLE, busy low within DIV/2+3 cycles.
5. out_ready=0; send 0x01..0x05, FIFO_DEPTH=4 -> overrun pulses once (on 0x05). Drain yields 0x01,0x02,0x03,0x04 in order, then out_valid=0.
6. Assert reset in the middle of bit 4 of 0x7E with 2 entries queued -> out_valid=0 immediately. After release, 0x81 is received correctly as the sole entry.
